// File: rtl/axis_splitter_tdest.sv
// AXI-Stream demultiplexer: routes whole packets to the output selected by the
// first-beat tdest, discards out-of-range packets and counts them.
module axis_splitter_tdest #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 2
) (
  input  logic                                  clk,
  input  logic                                  sreset,
  input  logic                                  enable,
  input  logic [8*AXIS_BYTES-1:0]               axis_i_tdata,
  input  logic [AXIS_BYTES-1:0]                 axis_i_tkeep,
  input  logic [AXIS_USER_BITS-1:0]             axis_i_tuser,
  input  logic [AXIS_BYTES-1:0]                 axis_i_tdest,
  input  logic                                  axis_i_tlast,
  input  logic                                  axis_i_tvalid,
  output logic                                  axis_i_tready,
  output logic [NUM_STREAMS*8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [NUM_STREAMS*AXIS_BYTES-1:0]     axis_o_tkeep,
  output logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic [NUM_STREAMS*AXIS_BYTES-1:0]     axis_o_tdest,
  output logic [NUM_STREAMS-1:0]                axis_o_tlast,
  output logic [NUM_STREAMS-1:0]                axis_o_tvalid,
  input  logic [NUM_STREAMS-1:0]                axis_o_tready,
  output logic [15:0]                           drop_count
);

  localparam int          CTR_WIDTH     = (NUM_STREAMS == 1) ? 1 : $clog2(NUM_STREAMS);
  localparam logic [31:0] NUM_STREAMS_U = NUM_STREAMS;

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DROP
  } state_t;

  typedef struct packed {
    logic [8*AXIS_BYTES-1:0]   data;
    logic [AXIS_BYTES-1:0]     keep;
    logic [AXIS_USER_BITS-1:0] user;
    logic [AXIS_BYTES-1:0]     tdest;
    logic                      last;
    logic [CTR_WIDTH-1:0]      tag;
  } entry_t;

  state_t               state_q, state_d;
  logic [CTR_WIDTH-1:0] sel_q;
  logic [AXIS_BYTES-1:0] pkt_tdest_q;

  entry_t main_q, skid_q, in_entry;
  logic   main_valid_q, skid_valid_q;

  logic in_range;
  logic in_ready;
  logic push;
  logic first_drop;
  logic main_fire;

  assign in_range = 32'(axis_i_tdest) < NUM_STREAMS_U;

  // ---------------------------------------------------------------------------
  // Packet FSM: decides readiness and whether an accepted beat is buffered
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    push           = 1'b0;
    first_drop     = 1'b0;
    in_entry.data  = axis_i_tdata;
    in_entry.keep  = axis_i_tkeep;
    in_entry.user  = axis_i_tuser;
    in_entry.tdest = pkt_tdest_q;
    in_entry.last  = axis_i_tlast;
    in_entry.tag   = sel_q;

    if (!sreset) begin
      case (state_q)
        IDLE: begin
          in_ready       = !skid_valid_q && enable;
          in_entry.tdest = axis_i_tdest;
          in_entry.tag   = CTR_WIDTH'(axis_i_tdest);
          if (axis_i_tvalid && in_ready) begin
            if (in_range) begin
              push = 1'b1;
              if (!axis_i_tlast) state_d = FORWARD;
            end else begin
              first_drop = 1'b1;
              if (!axis_i_tlast) state_d = DROP;
            end
          end
        end

        FORWARD: begin
          in_ready = !skid_valid_q;
          if (axis_i_tvalid && in_ready) begin
            push = 1'b1;
            if (axis_i_tlast) state_d = IDLE;
          end
        end

        DROP: begin
          // Discarded beats never touch the buffer, so back-pressure is irrelevant.
          in_ready = 1'b1;
          if (axis_i_tvalid && axis_i_tlast) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign axis_i_tready = in_ready;

  // ---------------------------------------------------------------------------
  // Output side: only the tagged stream sees tvalid, buses are shared
  // ---------------------------------------------------------------------------
  always_comb begin
    axis_o_tvalid = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      axis_o_tvalid[i] = main_valid_q && (main_q.tag == CTR_WIDTH'(i));
    end
  end

  assign main_fire    = |(axis_o_tvalid & axis_o_tready);
  assign axis_o_tdata = {NUM_STREAMS{main_q.data}};
  assign axis_o_tkeep = {NUM_STREAMS{main_q.keep}};
  assign axis_o_tuser = {NUM_STREAMS{main_q.user}};
  assign axis_o_tdest = {NUM_STREAMS{main_q.tdest}};
  assign axis_o_tlast = {NUM_STREAMS{main_q.last}};

  // ---------------------------------------------------------------------------
  // State, selection, drop counter and the main/skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      pkt_tdest_q  <= '0;
      drop_count   <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: buffer payloads are left unreset; only the flags that are visible
      // on the outputs (valid, last) need a known value.
      main_q.last  <= 1'b0;
      skid_q.last  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && push) begin
        sel_q       <= in_entry.tag;
        pkt_tdest_q <= axis_i_tdest;
      end

      if (first_drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end

      // Skid is only ever occupied while main is, and input is blocked while
      // skid is occupied, so push and skid_valid_q are never both set.
      if (!main_valid_q || main_fire) begin
        if (skid_valid_q) begin
          main_q       <= skid_q;
          main_valid_q <= 1'b1;
          skid_valid_q <= 1'b0;
        end else begin
          main_valid_q <= push;
          if (push) main_q <= in_entry;
        end
      end else if (push) begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end
    end
  end

  a_skid_implies_main : assert property (
    @(posedge clk) disable iff (sreset) skid_valid_q |-> main_valid_q);

  a_output_stable : assert property (
    @(posedge clk) disable iff (sreset)
      (main_valid_q && !main_fire) |=> (main_valid_q && $stable(main_q)));

endmodule

// File: tb/tb_axis_splitter_tdest.sv
// Bench for axis_splitter_tdest: vector table, directed corner sequences and
// randomized traffic checked against a packet-level scoreboard.
module tb_axis_splitter_tdest;

  localparam int AB = 4;
  localparam int UB = 2;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              sreset = 1'b1;
  logic              enable = 1'b1;
  logic [8*AB-1:0]   axis_i_tdata = '0;
  logic [AB-1:0]     axis_i_tkeep = '0;
  logic [UB-1:0]     axis_i_tuser = '0;
  logic [AB-1:0]     axis_i_tdest = '0;
  logic              axis_i_tlast = 1'b0;
  logic              axis_i_tvalid = 1'b0;
  logic              axis_i_tready;
  logic [NS*8*AB-1:0] axis_o_tdata;
  logic [NS*AB-1:0]  axis_o_tkeep;
  logic [NS*UB-1:0]  axis_o_tuser;
  logic [NS*AB-1:0]  axis_o_tdest;
  logic [NS-1:0]     axis_o_tlast;
  logic [NS-1:0]     axis_o_tvalid;
  logic [NS-1:0]     axis_o_tready = '0;
  logic [15:0]       drop_count;

  axis_splitter_tdest #(
    .AXIS_BYTES    (AB),
    .AXIS_USER_BITS(UB),
    .NUM_STREAMS   (NS)
  ) dut (
    .clk          (clk),
    .sreset       (sreset),
    .enable       (enable),
    .axis_i_tdata (axis_i_tdata),
    .axis_i_tkeep (axis_i_tkeep),
    .axis_i_tuser (axis_i_tuser),
    .axis_i_tdest (axis_i_tdest),
    .axis_i_tlast (axis_i_tlast),
    .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tready(axis_i_tready),
    .axis_o_tdata (axis_o_tdata),
    .axis_o_tkeep (axis_o_tkeep),
    .axis_o_tuser (axis_o_tuser),
    .axis_o_tdest (axis_o_tdest),
    .axis_o_tlast (axis_o_tlast),
    .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tready(axis_o_tready),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: expected beats per output, built from whole-packet routing rules
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [8*AB-1:0] data;
    logic [AB-1:0]   keep;
    logic [UB-1:0]   user;
    logic [AB-1:0]   tdest;
    logic            last;
  } obeat_t;

  obeat_t    exp_q[NS][$];
  bit        mon_en = 1'b0;
  bit        in_pkt = 1'b0;
  int        pkt_route = -1;
  logic [AB-1:0] pkt_tdest = '0;
  int        exp_drops = 0;
  bit        hold[NS];
  obeat_t    held[NS];

  function automatic obeat_t out_beat(input int i);
    obeat_t b;
    b.data  = axis_o_tdata[i*8*AB +: 8*AB];
    b.keep  = axis_o_tkeep[i*AB +: AB];
    b.user  = axis_o_tuser[i*UB +: UB];
    b.tdest = axis_o_tdest[i*AB +: AB];
    b.last  = axis_o_tlast[i];
    return b;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("drop_count", 64'(drop_count), 64'(exp_drops));
      check("valid_onehot", 64'($countones(axis_o_tvalid) <= 1), 64'd1);
      for (int i = 0; i < NS; i++) begin
        if (hold[i]) begin
          check("hold_valid", 64'(axis_o_tvalid[i]), 64'd1);
          check("hold_beat", 64'(out_beat(i)), 64'(held[i]));
        end
      end
      if (sreset) begin
        for (int i = 0; i < NS; i++) begin
          exp_q[i].delete();
          hold[i] = 1'b0;
        end
        in_pkt    = 1'b0;
        exp_drops = 0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          hold[i] = axis_o_tvalid[i] && !axis_o_tready[i];
          held[i] = out_beat(i);
          if (axis_o_tvalid[i] && axis_o_tready[i]) begin
            check("beat_expected", 64'(exp_q[i].size() != 0), 64'd1);
            if (exp_q[i].size() != 0) check("out_beat", 64'(out_beat(i)), 64'(exp_q[i].pop_front()));
          end
        end
        if (axis_i_tvalid && axis_i_tready) begin
          if (!in_pkt) begin
            pkt_tdest = axis_i_tdest;
            pkt_route = (int'(axis_i_tdest) < NS) ? int'(axis_i_tdest) : -1;
            if (pkt_route < 0 && exp_drops < 65535) exp_drops++;
          end
          if (pkt_route >= 0)
            exp_q[pkt_route].push_back({axis_i_tdata, axis_i_tkeep, axis_i_tuser, pkt_tdest, axis_i_tlast});
          in_pkt = !axis_i_tlast;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Drivers (all called at posedge+1)
  // ---------------------------------------------------------------------------
  bit rand_bp = 1'b0;

  task automatic randomize_knobs();
    for (int i = 0; i < NS; i++) axis_o_tready[i] = ($urandom_range(0, 3) != 0);
    enable = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] dest, input logic last,
                       input logic [3:0] keep, input logic [1:0] user);
    axis_i_tdata  = d;
    axis_i_tdest  = dest;
    axis_i_tlast  = last;
    axis_i_tkeep  = keep;
    axis_i_tuser  = user;
    axis_i_tvalid = 1'b1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] dest, input logic last,
                           input logic [3:0] keep, input logic [1:0] user);
    bit done = 1'b0;
    int waited = 0;
    drive(d, dest, last, keep, user);
    while (!done && waited < 200) begin
      @(negedge clk);
      done = axis_i_tready;
      @(posedge clk);
      #1;
      waited++;
      if (rand_bp) randomize_knobs();
    end
    axis_i_tvalid = 1'b0;
    check("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    axis_i_tvalid = 1'b0;
    axis_o_tready = '1;
    enable        = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Back-to-back stream with all outputs ready: checks acceptance every cycle
  // and one-cycle latency of each beat on its output.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
    int          exp_out;
    logic [3:0]  exp_tdest;
  } sbeat_t;

  sbeat_t stim_q[$];

  task automatic check_out(input sbeat_t b);
    logic [NS-1:0] expv;
    expv = (b.exp_out < 0) ? '0 : NS'(1) << b.exp_out;
    check("stream_valid", 64'(axis_o_tvalid), 64'(expv));
    if (b.exp_out >= 0) begin
      check("stream_data", 64'(axis_o_tdata[b.exp_out*32 +: 32]), 64'(b.data));
      check("stream_tdest", 64'(axis_o_tdest[b.exp_out*4 +: 4]), 64'(b.exp_tdest));
      check("stream_last", 64'(axis_o_tlast[b.exp_out]), 64'(b.last));
    end
  endtask

  task automatic run_stream();
    for (int k = 0; k < stim_q.size(); k++) begin
      drive(stim_q[k].data, stim_q[k].dest, stim_q[k].last, 4'hF, 2'd0);
      @(negedge clk);
      check("stream_ready", 64'(axis_i_tready), 64'd1);
      if (k > 0) check_out(stim_q[k-1]);
      @(posedge clk);
      #1;
    end
    axis_i_tvalid = 1'b0;
    @(negedge clk);
    check_out(stim_q[stim_q.size()-1]);
    @(posedge clk);
    #1;
    stim_q.delete();
  endtask

  typedef struct {
    logic [3:0]  tdest;
    logic [31:0] data;
    logic [3:0]  exp_valid;
    int          exp_idx;
    logic [15:0] exp_drops;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int acc;
    vecs[0] = '{4'd0,  32'hA5A5_0000, 4'b0001, 0, 16'd0};
    vecs[1] = '{4'd1,  32'hA5A5_0001, 4'b0010, 1, 16'd0};
    vecs[2] = '{4'd2,  32'hA5A5_0002, 4'b0100, 2, 16'd0};
    vecs[3] = '{4'd3,  32'hA5A5_0003, 4'b1000, 3, 16'd0};
    vecs[4] = '{4'd4,  32'hA5A5_0004, 4'b0000, 0, 16'd1};
    vecs[5] = '{4'd7,  32'hA5A5_0007, 4'b0000, 0, 16'd2};
    vecs[6] = '{4'd15, 32'hA5A5_000F, 4'b0000, 0, 16'd3};
    vecs[7] = '{4'd3,  32'h5A5A_0003, 4'b1000, 3, 16'd3};
    vecs[8] = '{4'd0,  32'h5A5A_0000, 4'b0001, 0, 16'd3};

    // Reset state
    sreset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(axis_i_tready), 64'd0);
    check("rst_out_valid", 64'(axis_o_tvalid), 64'd0);
    check("rst_out_last", 64'(axis_o_tlast), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(axis_i_tready), 64'd1);
    @(posedge clk);
    #1;

    // Single-beat packets from the vector table, held in main until released
    foreach (vecs[v]) begin
      axis_o_tready = '0;
      drive(vecs[v].data, vecs[v].tdest, 1'b1, 4'hF, 2'd1);
      @(negedge clk);
      check("vec_ready", 64'(axis_i_tready), 64'd1);
      @(posedge clk);
      #1;
      axis_i_tvalid = 1'b0;
      @(negedge clk);
      check("vec_valid", 64'(axis_o_tvalid), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid != 0) begin
        check("vec_data", 64'(axis_o_tdata[vecs[v].exp_idx*32 +: 32]), 64'(vecs[v].data));
        check("vec_tdest", 64'(axis_o_tdest[vecs[v].exp_idx*4 +: 4]), 64'(vecs[v].tdest));
      end
      check("vec_drops", 64'(drop_count), 64'(vecs[v].exp_drops));
      @(posedge clk);
      #1;
      axis_o_tready = '1;
      @(posedge clk);
      #1;
    end
    drain();

    // Four 3-beat packets to outputs 0..3, continuous
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 3; b++)
        stim_q.push_back('{32'h1000_0000 | (p << 8) | b, 4'(p), (b == 2), p, 4'(p)});
    run_stream();
    drain();

    // Later beats carry a different tdest; the packet tdest sticks
    stim_q.push_back('{32'h2000_0000, 4'd2, 1'b0, 2, 4'd2});
    stim_q.push_back('{32'h2000_0001, 4'd0, 1'b0, 2, 4'd2});
    stim_q.push_back('{32'h2000_0002, 4'd0, 1'b1, 2, 4'd2});
    run_stream();
    drain();

    // Out-of-range 5-beat packet is consumed silently, next packet routes
    for (int b = 0; b < 5; b++) stim_q.push_back('{32'h3000_0000 | b, 4'd7, (b == 4), -1, 4'd0});
    for (int b = 0; b < 3; b++) stim_q.push_back('{32'h3100_0000 | b, 4'd1, (b == 2), 1, 4'd1});
    run_stream();
    check("drop_after_pkt", 64'(drop_count), 64'd4);
    drain();

    // Back-pressure on output 0 during a 6-beat packet
    axis_o_tready = 4'b1110;
    acc = 0;
    drive(32'hB000_0000, 4'd0, 1'b0, 4'hF, 2'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) check("bp_ready_drop", 64'(axis_i_tready), 64'd0);
      if (axis_i_tready) acc++;
      @(posedge clk);
      #1;
      drive(32'hB000_0000 | acc, 4'd0, (acc == 5), 4'hF, 2'd2);
    end
    check("bp_accepted", 64'(acc), 64'd2);
    axis_o_tready = 4'b1111;
    @(negedge clk);
    check("bp_still_low", 64'(axis_i_tready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_rerise", 64'(axis_i_tready), 64'd1);
    @(posedge clk);
    #1;
    for (int k = 3; k < 6; k++) send_beat(32'hB000_0000 | k, 4'd0, (k == 5), 4'hF, 2'd2);
    drain();

    // enable low mid-packet: packet completes, next one stalls
    send_beat(32'hC000_0000, 4'd3, 1'b0, 4'hF, 2'd3);
    enable = 1'b0;
    send_beat(32'hC000_0001, 4'd3, 1'b0, 4'hF, 2'd3);
    send_beat(32'hC000_0002, 4'd3, 1'b1, 4'hF, 2'd3);
    drive(32'hC100_0000, 4'd2, 1'b0, 4'hF, 2'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("en_stall", 64'(axis_i_tready), 64'd0);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    send_beat(32'hC100_0000, 4'd2, 1'b0, 4'hF, 2'd3);
    send_beat(32'hC100_0001, 4'd2, 1'b1, 4'hF, 2'd3);
    drain();

    // Reset during beat 2 of a 4-beat packet
    axis_o_tready = '0;
    send_beat(32'hD000_0000, 4'd1, 1'b0, 4'hF, 2'd0);
    drive(32'hD000_0001, 4'd1, 1'b0, 4'hF, 2'd0);
    sreset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(axis_i_tready), 64'd0);
    @(posedge clk);
    #1;
    sreset = 1'b0;
    axis_i_tvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(axis_o_tvalid), 64'd0);
    check("mid_rst_drops", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    axis_o_tready = '1;
    stim_q.push_back('{32'hD100_0000, 4'd2, 1'b0, 2, 4'd2});
    stim_q.push_back('{32'hD100_0001, 4'd2, 1'b1, 2, 4'd2});
    run_stream();
    drain();

    // Randomized packets, random destinations, back-pressure and enable
    rand_bp = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      logic [3:0] dest;
      len  = $urandom_range(1, 5);
      dest = 4'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        send_beat($urandom, (b == 0) ? dest : 4'($urandom), (b == len - 1),
                  4'($urandom), 2'($urandom));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        randomize_knobs();
      end
    end
    rand_bp = 1'b0;
    drain();
    for (int i = 0; i < NS; i++) check("drain_empty", 64'(exp_q[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
